// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 codes, FSM states,
// byte-enable patterns and the request fields latched at accept.
package lsu_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned BE_BITS  = 4;
  localparam int unsigned RD_W     = 5;

  localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

  localparam logic [BE_BITS-1:0] BE_BYTE = 4'b0001;
  localparam logic [BE_BITS-1:0] BE_HALF = 4'b0011;
  localparam logic [BE_BITS-1:0] BE_WORD = 4'b1111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } lsu_state_t;

  typedef struct packed {
    logic                is_store;
    logic [FUNCT3_W-1:0] funct3;
    logic [1:0]          addr_lo;
    logic [RD_W-1:0]     rd;
  } lsu_req_t;

  // Stores have no unsigned variants, so every 1xx store encoding is illegal.
  function automatic logic f3_illegal(input logic is_store, input logic [FUNCT3_W-1:0] f3);
    if (is_store) return (f3 == 3'b011) || f3[2];
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the byte/half lane addressed by addr_lo and
// sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0]   rdata,
  input  logic [1:0]          addr_lo,
  input  logic [FUNCT3_W-1:0] funct3,
  output logic [WORD_W-1:0]   data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data_c = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_c = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data_c = {24'b0, byte_sel};
      F3_HU:   data_c = {16'b0, half_sel};
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one req/gnt/rvalid data-memory transaction per accepted request.
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses raise lsu_err instead.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_is_store,
  input  logic [FUNCT3_W-1:0] req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [RD_W-1:0]     req_rd,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [BE_BITS-1:0]  mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                wb_valid,
  output logic [RD_W-1:0]     wb_rd,
  output logic [DATA_W-1:0]   wb_data,
  output logic                st_done,
  output logic                lsu_err
);

  lsu_state_t          state, state_next;
  lsu_req_t            req_q;
  logic                accept_c, illegal_c, trap_c;
  logic [BE_BITS-1:0]  be_c;
  logic [DATA_W-1:0]   wdata_c, load_data_c;

  logic                req_ready_d, mem_req_d, mem_we_d, wb_valid_d, st_done_d, lsu_err_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [BE_BITS-1:0]  mem_be_d;
  logic [DATA_W-1:0]   mem_wdata_d, wb_data_d;
  logic [RD_W-1:0]     wb_rd_d;

  assign accept_c  = req_valid && req_ready;
  assign illegal_c = f3_illegal(req_is_store, req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign trap_c = 1'b0;
`endif

  // Byte enables and lane-replicated store data from the incoming request.
  always_comb begin
    be_c    = BE_WORD;
    wdata_c = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_c    = BE_BYTE << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = BE_HALF << {req_addr[1], 1'b0};
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_align u_load_align (
    .rdata  (mem_rdata),
    .addr_lo(req_q.addr_lo),
    .funct3 (req_q.funct3),
    .data_c (load_data_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_c) state_next = (illegal_c || trap_c) ? ERR : REQ;
      REQ:     if (mem_gnt) state_next = req_q.is_store ? DONE : WAIT;
      WAIT:    if (mem_rvalid) state_next = DONE;
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the state being entered.
  always_comb begin
    req_ready_d = (state_next == IDLE);
    mem_req_d   = (state_next == REQ);
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_be_d    = '0;
    mem_wdata_d = '0;
    wb_valid_d  = (state_next == DONE) && !req_q.is_store;
    st_done_d   = (state_next == DONE) && req_q.is_store;
    lsu_err_d   = (state_next == ERR);
    wb_rd_d     = wb_rd;
    wb_data_d   = wb_data;
    if (state_next == REQ) begin
      if (state == IDLE) begin
        mem_we_d    = req_is_store;
        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
        mem_be_d    = be_c;
        mem_wdata_d = wdata_c;
      end else begin
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_be_d    = mem_be;
        mem_wdata_d = mem_wdata;
      end
    end
    if ((state == WAIT) && mem_rvalid) begin
      wb_rd_d   = req_q.rd;
      wb_data_d = load_data_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q     <= '0;
      req_ready <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      st_done   <= 1'b0;
      lsu_err   <= 1'b0;
    end else begin
      if (accept_c) begin
        req_q.is_store <= req_is_store;
        req_q.funct3   <= req_funct3;
        req_q.addr_lo  <= req_addr[1:0];
        req_q.rd       <= req_rd;
      end
      req_ready <= req_ready_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_be    <= mem_be_d;
      mem_wdata <= mem_wdata_d;
      wb_valid  <= wb_valid_d;
      wb_rd     <= wb_rd_d;
      wb_data   <= wb_data_d;
      st_done   <= st_done_d;
      lsu_err   <= lsu_err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, random transactions
// against a reference model, and hand-written reset-abort sequences.
module tb_load_store_unit;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, st_done, lsu_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int nvec = 0;
  int nmis = 0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .st_done(st_done), .lsu_err(lsu_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    string       tag;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    logic [4:0]  rd;
    int          g, r;
    exp_t        e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: access size in bytes, lane offset and extension computed arithmetically.
  function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t e;
    int size, off;
    logic [31:0] mask;
    e = '{err: 1'b0, be: 4'h0, wdata: 32'h0, data: 32'h0};
    size = 1 << int'(f3[1:0]);
    e.err = st ? ((f3 == 3'd3) || (f3 >= 3'd4)) : ((f3 == 3'd3) || (f3 >= 3'd6));
`ifdef LSU_MISALIGN_TRAP_EN
    if (!e.err && size > 1 && (int'(addr[1:0]) % size) != 0) e.err = 1'b1;
`endif
    if (e.err) return e;
    off = (int'(addr[1:0]) / size) * size;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + size) e.be[i] = 1'b1;
      e.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
    end
    e.data = rdata >> (8 * off);
    if (size < 4) begin
      mask = (32'h1 << (8 * size)) - 32'h1;
      e.data = e.data & mask;
      if (!f3[2] && e.data[8*size-1]) e.data = e.data | ~mask;
    end
    return e;
  endfunction

  // One transaction with a behavioural memory: gnt after g REQ cycles, rvalid r cycles after gnt.
  task automatic do_txn(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic [4:0] rd, input int g, input int r, input bit noise, input exp_t e);
    int cyc, req_cnt, gnt_cyc, done_cyc, err_cyc, ready_cyc, wb_cnt, st_cnt, err_cnt, leak, unstable;
    int exp_done, exp_ready;
    logic [31:0] a_addr, a_wdata, a_data;
    logic [3:0]  a_be;
    logic        a_we;
    logic [4:0]  a_rd;
    req_cnt = 0; gnt_cyc = -1; done_cyc = -1; err_cyc = -1; ready_cyc = -1;
    wb_cnt = 0; st_cnt = 0; err_cnt = 0; leak = 0; unstable = 0;
    a_addr = '0; a_wdata = '0; a_data = '0; a_be = '0; a_we = 1'b0; a_rd = '0;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(posedge clk); #1;
    cyc = 1;
    while (cyc <= 40) begin
      req_valid = noise && ($urandom_range(0, 1) == 1) && !req_ready;
      req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (mem_req) begin
        if (req_cnt == 0) begin
          a_addr = mem_addr; a_be = mem_be; a_wdata = mem_wdata; a_we = mem_we;
        end else if ({mem_addr, mem_be, mem_wdata, mem_we} != {a_addr, a_be, a_wdata, a_we}) begin
          unstable++;
        end
        if (req_cnt == g) begin mem_gnt = 1'b1; gnt_cyc = cyc; end
        if (noise) mem_rvalid = 1'($urandom);
        req_cnt++;
      end else begin
        if (mem_we || mem_be != 4'h0 || mem_wdata != 32'h0 || mem_addr != 32'h0) leak++;
        if (noise) mem_gnt = 1'($urandom);
        if (!st && gnt_cyc >= 0 && cyc == gnt_cyc + r) begin
          mem_rvalid = 1'b1; mem_rdata = rdata;
        end else if (noise && (wb_valid || st_done || lsu_err)) begin
          mem_rvalid = 1'($urandom);
        end
      end
      if (wb_valid) begin wb_cnt++; done_cyc = cyc; a_data = wb_data; a_rd = wb_rd; end
      if (st_done) begin st_cnt++; done_cyc = cyc; end
      if (lsu_err) begin err_cnt++; err_cyc = cyc; end
      if (req_ready) begin ready_cyc = cyc; break; end
      @(posedge clk); #1;
      cyc++;
    end
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;

    exp_done  = st ? 2 + g : 2 + g + r;
    exp_ready = e.err ? 2 : exp_done + 1;
    check({tag, ".ready_cyc"}, 32'(ready_cyc), 32'(exp_ready));
    check({tag, ".err_cnt"}, 32'(err_cnt), e.err ? 32'd1 : 32'd0);
    check({tag, ".leak"}, 32'(leak), 32'd0);
    if (e.err) begin
      check({tag, ".err_cyc"}, 32'(err_cyc), 32'd1);
      check({tag, ".req_cnt"}, 32'(req_cnt), 32'd0);
      check({tag, ".done_cnt"}, 32'(wb_cnt + st_cnt), 32'd0);
    end else begin
      check({tag, ".req_cnt"}, 32'(req_cnt), 32'(g + 1));
      check({tag, ".unstable"}, 32'(unstable), 32'd0);
      check({tag, ".addr"}, a_addr, {addr[31:2], 2'b00});
      check({tag, ".be"}, 32'(a_be), 32'(e.be));
      check({tag, ".we"}, 32'(a_we), 32'(st));
      check({tag, ".done_cyc"}, 32'(done_cyc), 32'(exp_done));
      if (st) begin
        check({tag, ".wdata"}, a_wdata, e.wdata);
        check({tag, ".st_cnt"}, 32'(st_cnt), 32'd1);
        check({tag, ".wb_cnt"}, 32'(wb_cnt), 32'd0);
      end else begin
        check({tag, ".wb_cnt"}, 32'(wb_cnt), 32'd1);
        check({tag, ".st_cnt"}, 32'(st_cnt), 32'd0);
        check({tag, ".wb_data"}, a_data, e.data);
        check({tag, ".wb_rd"}, 32'(a_rd), 32'(rd));
      end
    end
    @(posedge clk); #1;
  endtask

  vec_t tbl[$];

  initial begin
    int wbc;
    logic        rs;
    logic [2:0]  rf3;
    logic [31:0] ra, rw, rr;
    exp_t        re;

    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_be", 32'(mem_be), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.pulses", 32'({wb_valid, st_done, lsu_err}), 32'd0);
    check("rst.wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    tbl.push_back('{"sw",     1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        5'd0,  0, 1, '{1'b0, 4'b1111, 32'hDEADBEEF, 32'h0}});
    tbl.push_back('{"sb",     1'b1, 3'b000, 32'h103, 32'h000000AB, 32'h0,        5'd0,  0, 1, '{1'b0, 4'b1000, 32'hABABABAB, 32'h0}});
    tbl.push_back('{"sh",     1'b1, 3'b001, 32'h106, 32'h1234BEEF, 32'h0,        5'd0,  1, 1, '{1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0}});
    tbl.push_back('{"lb",     1'b0, 3'b000, 32'h101, 32'h0,        32'h00008000, 5'd3,  0, 1, '{1'b0, 4'b0010, 32'h0, 32'hFFFFFF80}});
    tbl.push_back('{"lbu",    1'b0, 3'b100, 32'h101, 32'h0,        32'h00008000, 5'd4,  0, 1, '{1'b0, 4'b0010, 32'h0, 32'h00000080}});
    tbl.push_back('{"lhu",    1'b0, 3'b101, 32'h102, 32'h0,        32'hF00D0000, 5'd5,  0, 1, '{1'b0, 4'b1100, 32'h0, 32'h0000F00D}});
    tbl.push_back('{"lh",     1'b0, 3'b001, 32'h102, 32'h0,        32'h80010000, 5'd6,  0, 1, '{1'b0, 4'b1100, 32'h0, 32'hFFFF8001}});
    tbl.push_back('{"lw_slow",1'b0, 3'b010, 32'h200, 32'h0,        32'h12345678, 5'd31, 3, 2, '{1'b0, 4'b1111, 32'h0, 32'h12345678}});
    tbl.push_back('{"lb_x0",  1'b0, 3'b000, 32'h100, 32'h0,        32'h0000007F, 5'd0,  0, 1, '{1'b0, 4'b0001, 32'h0, 32'h0000007F}});
    tbl.push_back('{"ld_ill", 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        5'd1,  0, 1, '{1'b1, 4'h0, 32'h0, 32'h0}});
    tbl.push_back('{"st_ill", 1'b1, 3'b100, 32'h100, 32'h1,        32'h0,        5'd1,  0, 1, '{1'b1, 4'h0, 32'h0, 32'h0}});
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back('{"lh_mis", 1'b0, 3'b001, 32'h101, 32'h0,        32'hCAFE8001, 5'd9,  0, 1, '{1'b1, 4'h0, 32'h0, 32'h0}});
`else
    tbl.push_back('{"lh_mis", 1'b0, 3'b001, 32'h101, 32'h0,        32'hCAFE8001, 5'd9,  0, 1, '{1'b0, 4'b0011, 32'h0, 32'hFFFF8001}});
`endif

    foreach (tbl[i])
      do_txn(tbl[i].tag, tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
             tbl[i].rd, tbl[i].g, tbl[i].r, 1'b0, tbl[i].e);

    for (int n = 0; n < 60; n++) begin
      rs = 1'($urandom); rf3 = 3'($urandom);
      ra = $urandom; rw = $urandom; rr = $urandom;
      re = model(rs, rf3, ra, rw, rr);
      do_txn($sformatf("rnd%0d", n), rs, rf3, ra, rw, rr, 5'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 1'b1, re);
    end

    // Reset while waiting for read data: the late rvalid must not produce a writeback.
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300; req_rd = 5'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstw.mem_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check("rstw.wait_req", 32'(mem_req), 32'd0);
    check("rstw.wait_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstw.ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA; wbc = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (wb_valid) wbc++;
    end
    mem_rvalid = 1'b0;
    check("rstw.wb_cnt", 32'(wbc), 32'd0);
    check("rstw.ready_after", 32'(req_ready), 32'd1);

    // Reset during REQ drops mem_req at that edge.
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h404; req_wdata = 32'h1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstq.mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstq.mem_req_drop", 32'(mem_req), 32'd0);
    check("rstq.mem_be", 32'(mem_be), 32'd0);
    check("rstq.st_done", 32'(st_done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
